// File: rtl/uart_periph_if.sv
// uart_periph_if: MEM-stage data-bus bundle for the UART peripheral.
//   addr     32  byte address (addr[1:0] ignored by the peripheral)
//   wdata    32  store data
//   MemRead   1  load strobe, one cycle per access
//   MemWrite  1  store strobe, one cycle per access
//   rdata    32  combinational read data from the peripheral
// Handshake: there is no valid/ready pair. MemRead/MemWrite act as "valid",
// and the peripheral is always ready. An access completes in the cycle in
// which its strobe is high: rdata is valid in that cycle, and any side effect
// takes place at the closing clock edge.
interface uart_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] rdata;

    modport master (output addr, wdata, MemRead, MemWrite, input rdata);
    modport slave  (input addr, wdata, MemRead, MemWrite, output rdata);
endinterface

// File: rtl/uart_periph.sv
// uart_periph: memory-mapped 8N1 UART with TXD/RXD/CON registers and a level irq.
//   clk, rst      system clock and synchronous active-high reset
//   bus           uart_periph_if.slave (addr/wdata/MemRead/MemWrite/rdata)
//   rx            asynchronous serial input, idle high
//   tx            registered serial output, idle high
//   irq           registered level interrupt: (TXIE & TX_DONE) | (RXIE & RX_VALID)
//   dbg_tx_state  current TX FSM state
//   dbg_rx_state  current RX FSM state
// CON bits: [0]=TXIE [1]=RXIE [2]=TX_DONE [3]=RX_VALID [4]=TX_BUSY [5]=OVERRUN [6]=FRAME_ERR
module uart_periph #(
    parameter int          CLKS_PER_BIT = 5208,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic                clk,
    input  logic                rst,
    uart_periph_if.slave        bus,
    input  logic                rx,
    output logic                tx,
    output logic                irq,
    output logic [1:0]          dbg_tx_state,
    output logic [2:0]          dbg_rx_state
);
    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [29:0]    TXD_W    = BASE_ADDR[31:2];
    localparam logic [29:0]    RXD_W    = TXD_W + 30'd1;
    localparam logic [29:0]    CON_W    = TXD_W + 30'd2;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    // RX_BREAK holds off re-arming after a framing error until the line is high again.
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_e;

    tx_state_e     tx_state_q, tx_state_d;
    rx_state_e     rx_state_q, rx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]    txd_q, txd_d, rxd_q, rxd_d, rx_shift_q, rx_shift_d;
    logic          txie_q, txie_d, rxie_q, rxie_d;
    logic          tx_done_q, tx_done_d, rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic          tx_q, tx_d, irq_q, irq_d;
    logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;

    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, con_rd, rxd_rd, tx_busy;
    logic unused_bits;

    assign sel_txd = (bus.addr[31:2] == TXD_W);
    assign sel_rxd = (bus.addr[31:2] == RXD_W);
    assign sel_con = (bus.addr[31:2] == CON_W);
    assign txd_wr  = bus.MemWrite & sel_txd;
    assign con_wr  = bus.MemWrite & sel_con;
    assign con_rd  = bus.MemRead & sel_con;
    assign rxd_rd  = bus.MemRead & sel_rxd;
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8]};

    assign tx           = tx_q;
    assign irq          = irq_q;
    assign dbg_tx_state = tx_state_q;
    assign dbg_rx_state = rx_state_q;

    always_comb begin
        bus.rdata = 32'd0;
        if (bus.MemRead) begin
            if (sel_txd)      bus.rdata = {24'd0, txd_q};
            else if (sel_rxd) bus.rdata = {24'd0, rxd_q};
            else if (sel_con) bus.rdata = {25'd0, frame_err_q, overrun_q, tx_busy,
                                           rx_valid_q, tx_done_q, rxie_q, txie_q};
        end
    end

    always_comb begin
        tx_state_d  = tx_state_q;
        rx_state_d  = rx_state_q;
        tx_cnt_d    = tx_cnt_q;
        rx_cnt_d    = rx_cnt_q;
        tx_bit_d    = tx_bit_q;
        rx_bit_d    = rx_bit_q;
        txd_d       = txd_q;
        rxd_d       = rxd_q;
        rx_shift_d  = rx_shift_q;
        txie_d      = txie_q;
        rxie_d      = rxie_q;
        tx_done_d   = tx_done_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_s1_d     = rx;
        rx_s2_d     = rx_s1_q;

        if (con_wr) {rxie_d, txie_d} = bus.wdata[1:0];
        // Read-side clears come first so that a set event later in this block wins.
        if (con_rd) begin
            tx_done_d   = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end
        if (rxd_rd) rx_valid_d = 1'b0;

        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (txd_wr) begin
                    txd_d      = bus.wdata[7:0];
                    tx_done_d  = 1'b0;
                    tx_bit_d   = 3'd0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = TX_DATA;
                end else tx_cnt_d = tx_cnt_q + CW'(1);
            end
            TX_DATA: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                end else tx_cnt_d = tx_cnt_q + CW'(1);
            end
            default: begin
                if (tx_cnt_q == CNT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_done_d  = 1'b1;
                    tx_state_d = TX_IDLE;
                end else tx_cnt_d = tx_cnt_q + CW'(1);
            end
        endcase

        // tx is registered from the current state, so the line lags the FSM by one cycle.
        case (tx_state_q)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = txd_q[tx_bit_q];
            default:  tx_d = 1'b1;
        endcase

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end else rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        rxd_d      = rx_shift_q;
                        rx_valid_d = 1'b1;
                        if (rx_valid_q) overrun_d = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        rx_state_d  = RX_BREAK;
                    end
                end else rx_cnt_d = rx_cnt_q + CW'(1);
            end
            RX_BREAK: begin
                rx_cnt_d = '0;
                if (rx_s2_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        irq_d = (txie_q & tx_done_q) | (rxie_q & rx_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q  <= TX_IDLE;
            rx_state_q  <= RX_IDLE;
            tx_cnt_q    <= '0;
            rx_cnt_q    <= '0;
            tx_bit_q    <= 3'd0;
            rx_bit_q    <= 3'd0;
            txd_q       <= 8'd0;
            rxd_q       <= 8'd0;
            rx_shift_q  <= 8'd0;
            txie_q      <= 1'b0;
            rxie_q      <= 1'b0;
            tx_done_q   <= 1'b0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tx_q        <= 1'b1;
            irq_q       <= 1'b0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
        end else begin
            tx_state_q  <= tx_state_d;
            rx_state_q  <= rx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            rx_bit_q    <= rx_bit_d;
            txd_q       <= txd_d;
            rxd_q       <= rxd_d;
            rx_shift_q  <= rx_shift_d;
            txie_q      <= txie_d;
            rxie_q      <= rxie_d;
            tx_done_q   <= tx_done_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tx_q        <= tx_d;
            irq_q       <= irq_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
        end
    end
endmodule
